// File: rtl/ahb_slave_port_arbiter_pkg.sv
// Shared AHB types for the slave-port arbiter: burst/transfer encodings,
// arbitration modes and the burst-length helper.
package ahb_slave_port_arbiter_pkg;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        ARB_FIXED   = 2'd0,
        ARB_DYNAMIC = 2'd1,
        ARB_RR      = 2'd2
    } arb_mode_t;

    // Zero marks an undefined-length INCR burst.
    function automatic logic [4:0] burst_beats(hburst_type b);
        case (b)
            BURST_SINGLE:              return 5'd1;
            BURST_WRAP4, BURST_INCR4:  return 5'd4;
            BURST_WRAP8, BURST_INCR8:  return 5'd8;
            BURST_WRAP16, BURST_INCR16: return 5'd16;
            default:                   return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_pick.sv
// Combinational winner selection shared by the fixed, dynamic-priority and
// round-robin arbitration modes; produces a one-hot pick.
module ahb_arb_pick
    import ahb_slave_port_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int PRIOR_BIT  = 2,
    parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0]           req,
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] prior,
    input  logic [MIDX_W-1:0]               rr_ptr,
    input  logic [1:0]                      mode,
    output logic [MASTER_NUM-1:0]           pick
);

    logic                 found;
    logic [PRIOR_BIT-1:0] best_prior;

    always_comb begin
        pick       = '0;
        found      = 1'b0;
        best_prior = '0;
        case (arb_mode_t'(mode))
            ARB_DYNAMIC: begin
                // Strict compare keeps the lowest index on a priority tie.
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (req[i] && (!found || prior[i*PRIOR_BIT +: PRIOR_BIT] > best_prior)) begin
                        found      = 1'b1;
                        best_prior = prior[i*PRIOR_BIT +: PRIOR_BIT];
                        pick       = '0;
                        pick[i]    = 1'b1;
                    end
                end
            end
            ARB_RR: begin
                // Scan from the pointer upward, then wrap around to index 0.
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (!found && req[i] && i >= int'(rr_ptr)) begin
                        found   = 1'b1;
                        pick[i] = 1'b1;
                    end
                end
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (!found && req[i]) begin
                        found   = 1'b1;
                        pick[i] = 1'b1;
                    end
                end
            end
            default: begin
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (!found && req[i]) begin
                        found   = 1'b1;
                        pick[i] = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port AHB arbiter: grants one master, follows its burst beat by
// beat and re-arbitrates only at burst ends, owner release or lock exit.
module ahb_slave_port_arbiter
    import ahb_slave_port_arbiter_pkg::*;
#(
    parameter int        MASTER_NUM = 4,
    parameter int        PRIOR_BIT  = 2,
    parameter arb_mode_t ARB_MODE   = ARB_DYNAMIC,
    parameter int        INCR_MAX   = 16,
    parameter int        MIDX_W     = $clog2(MASTER_NUM)
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
    input  logic [2:0]                      hburst,
    input  logic [1:0]                      htrans,
    input  logic                            hmastlock,
    input  logic                            hwait,
    output logic [MASTER_NUM-1:0]           hgrant,
    output logic                            hsel,
    output logic [MIDX_W-1:0]               hmaster,
    output logic                            hlast
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;
    localparam logic [7:0] INCR_LAST = 8'(INCR_MAX - 1);

    logic [1:0]            state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [7:0]            count_q, count_d;
    hburst_type            burst_q, burst_d;
    logic [MIDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [MASTER_NUM-1:0] pick;
    logic [MIDX_W-1:0]     owner, owner_next, pick_ptr;
    hburst_type            cur_burst;
    logic [4:0]            limit;
    logic [7:0]            count_inc;
    logic                  beat, owner_req, last_hit, idle_drop;

    always_comb begin
        owner = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_q[i]) owner = MIDX_W'(i);
        end
    end

    assign owner_next = (int'(owner) == MASTER_NUM - 1) ? '0 : owner + MIDX_W'(1);
    // With an owner, the pick that follows it always starts just past it.
    assign pick_ptr   = hsel ? owner_next : rr_ptr_q;

    assign hsel      = |grant_q;
    assign hgrant    = grant_q & {MASTER_NUM{~hwait}};
    assign hmaster   = owner;
    assign owner_req = |(hreq & grant_q);
    assign beat      = hsel && !hwait && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);
    assign cur_burst = (htrans == TRANS_NONSEQ) ? hburst_type'(hburst) : burst_q;
    assign limit     = burst_beats(cur_burst);
    assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    assign idle_drop = !owner_req && (htrans == TRANS_IDLE) && (count_q == 8'd0);

    always_comb begin
        if (limit != 5'd0) last_hit = (count_q == {3'b000, limit - 5'd1});
        else               last_hit = !owner_req || (count_q == INCR_LAST);
    end

    assign hlast = beat && last_hit;

    ahb_arb_pick #(
        .MASTER_NUM (MASTER_NUM),
        .PRIOR_BIT  (PRIOR_BIT),
        .MIDX_W     (MIDX_W)
    ) u_pick (
        .req    (hreq),
        .prior  (hprior),
        .rr_ptr (pick_ptr),
        .mode   (ARB_MODE),
        .pick   (pick)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        count_d  = count_q;
        burst_d  = burst_q;
        rr_ptr_d = rr_ptr_q;
        if (!hwait) begin
            if (beat && htrans == TRANS_NONSEQ) burst_d = hburst_type'(hburst);
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (|hreq) begin
                        state_d = ST_BURST;
                        grant_d = pick;
                    end
                end
                ST_BURST: begin
                    if (hlast || idle_drop) begin
                        count_d  = '0;
                        rr_ptr_d = owner_next;
                        if (hmastlock) begin
                            state_d = ST_LOCK;
                        end else if (|hreq) begin
                            grant_d = pick;
                        end else begin
                            grant_d = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (beat) begin
                        count_d = count_inc;
                    end
                end
                ST_LOCK: begin
                    if (!hmastlock) begin
                        count_d  = '0;
                        rr_ptr_d = owner_next;
                        if (|hreq) begin
                            state_d = ST_BURST;
                            grant_d = pick;
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end
                    end else if (hlast) begin
                        count_d = '0;
                    end else if (beat) begin
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            count_q  <= '0;
            burst_q  <= BURST_SINGLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
            burst_q  <= burst_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Bench for ahb_slave_port_arbiter: fixed, dynamic and round-robin instances
// share one stimulus stream and are checked against an owner/beat model.
module tb_ahb_slave_port_arbiter;
    import ahb_slave_port_arbiter_pkg::*;

    logic       hclk;
    logic       hreset_n;
    logic [3:0] hreq;
    logic [7:0] hprior;
    logic [2:0] hburst;
    logic [1:0] htrans;
    logic       hmastlock;
    logic       hwait;

    logic [3:0] hgrant_o  [3];
    logic       hsel_o    [3];
    logic [1:0] hmaster_o [3];
    logic       hlast_o   [3];

    int vec_count   = 0;
    int miscompares = 0;

    string inst_name  [3] = '{"fix", "dyn", "rr"};
    int    mode_m     [3] = '{0, 1, 2};
    int    incr_max_m [3] = '{16, 16, 4};

    int owner_m  [3];
    int beats_m  [3];
    int burst_m  [3];
    int rrp_m    [3];
    bit locked_m [3];

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb_slave_port_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_FIXED), .INCR_MAX(16)) u_fix (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .htrans(htrans), .hmastlock(hmastlock), .hwait(hwait),
        .hgrant(hgrant_o[0]), .hsel(hsel_o[0]), .hmaster(hmaster_o[0]), .hlast(hlast_o[0]));

    ahb_slave_port_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_DYNAMIC), .INCR_MAX(16)) u_dyn (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .htrans(htrans), .hmastlock(hmastlock), .hwait(hwait),
        .hgrant(hgrant_o[1]), .hsel(hsel_o[1]), .hmaster(hmaster_o[1]), .hlast(hlast_o[1]));

    ahb_slave_port_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_RR), .INCR_MAX(4)) u_rr (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .htrans(htrans), .hmastlock(hmastlock), .hwait(hwait),
        .hgrant(hgrant_o[2]), .hsel(hsel_o[2]), .hmaster(hmaster_o[2]), .hlast(hlast_o[2]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [1:0] trans, input logic [2:0] burst,
                                 input logic lock, input logic wt);
        @(posedge hclk);
        #1;
        hreq      = req;
        htrans    = trans;
        hburst    = burst;
        hmastlock = lock;
        hwait     = wt;
    endtask

    function automatic int beats_for(input int b);
        case (b)
            0:       return 1;
            1:       return 0;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic bit req_bit(input logic [3:0] req, input int i);
        return ((int'(req) >> i) & 1) == 1;
    endfunction

    // Winner for a mode: fixed = lowest, dynamic = highest priority (lowest on tie),
    // round-robin = first requester at or after start, cyclic.
    function automatic int choose(input int mode, input int start, input logic [3:0] req, input logic [7:0] pri);
        int best = -1;
        int bp   = -1;
        if (mode == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (req_bit(req, i) && ((int'(pri) >> (2 * i)) & 3) > bp) begin
                    best = i;
                    bp   = (int'(pri) >> (2 * i)) & 3;
                end
            end
        end else if (mode == 2) begin
            for (int k = 0; k < 4; k++) begin
                if (best < 0 && req_bit(req, (start + k) % 4)) best = (start + k) % 4;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (best < 0 && req_bit(req, i)) best = i;
            end
        end
        return best;
    endfunction

    task automatic modelStep(input int m);
        bit         has, acc, oreq, last, drop;
        int         len, btype, nxt;
        logic [3:0] eg;
        if (!hreset_n) begin
            owner_m[m]  = -1;
            locked_m[m] = 1'b0;
            beats_m[m]  = 0;
            burst_m[m]  = 0;
            rrp_m[m]    = 0;
            checkOutput({inst_name[m], " rst hgrant"}, 32'(hgrant_o[m]), 32'd0);
            checkOutput({inst_name[m], " rst hsel"}, 32'(hsel_o[m]), 32'd0);
            checkOutput({inst_name[m], " rst hmaster"}, 32'(hmaster_o[m]), 32'd0);
            checkOutput({inst_name[m], " rst hlast"}, 32'(hlast_o[m]), 32'd0);
            return;
        end
        has   = owner_m[m] >= 0;
        eg    = (has && !hwait) ? 4'(1 << owner_m[m]) : 4'b0000;
        acc   = has && !hwait && (htrans == 2'd2 || htrans == 2'd3);
        btype = (htrans == 2'd2) ? int'(hburst) : burst_m[m];
        len   = beats_for(btype);
        oreq  = has && req_bit(hreq, owner_m[m]);
        if (len > 0) last = acc && (beats_m[m] == len - 1);
        else         last = acc && (!oreq || beats_m[m] == incr_max_m[m] - 1);

        checkOutput({inst_name[m], " hgrant"}, 32'(hgrant_o[m]), 32'(eg));
        checkOutput({inst_name[m], " hsel"}, 32'(hsel_o[m]), 32'(has));
        checkOutput({inst_name[m], " hmaster"}, 32'(hmaster_o[m]), has ? 32'(owner_m[m]) : 32'd0);
        checkOutput({inst_name[m], " hlast"}, 32'(hlast_o[m]), 32'(last));

        if (hwait) return;
        if (acc && htrans == 2'd2) burst_m[m] = int'(hburst);
        nxt = has ? (owner_m[m] + 1) % 4 : rrp_m[m];
        if (!has) begin
            if (hreq != 4'd0) owner_m[m] = choose(mode_m[m], rrp_m[m], hreq, hprior);
            beats_m[m] = 0;
        end else if (locked_m[m]) begin
            if (!hmastlock) begin
                rrp_m[m]    = nxt;
                owner_m[m]  = (hreq != 4'd0) ? choose(mode_m[m], nxt, hreq, hprior) : -1;
                locked_m[m] = 1'b0;
                beats_m[m]  = 0;
            end else if (acc) begin
                beats_m[m] = last ? 0 : (beats_m[m] < 255 ? beats_m[m] + 1 : 255);
            end
        end else begin
            drop = !oreq && htrans == 2'd0 && beats_m[m] == 0;
            if (last || drop) begin
                rrp_m[m]   = nxt;
                beats_m[m] = 0;
                if (hmastlock) locked_m[m] = 1'b1;
                else owner_m[m] = (hreq != 4'd0) ? choose(mode_m[m], nxt, hreq, hprior) : -1;
            end else if (acc) begin
                beats_m[m] = beats_m[m] < 255 ? beats_m[m] + 1 : 255;
            end
        end
    endtask

    // Inputs only change just after a rising edge, so the falling edge sees the
    // same values the next rising edge will sample.
    always @(negedge hclk) begin
        for (int m = 0; m < 3; m++) modelStep(m);
    end

    logic [1:0] c_trans [10] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic       c_wait  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        hreset_n  = 1'b0;
        hreq      = 4'b0000;
        hprior    = 8'b11_01_11_00;
        hburst    = 3'd0;
        htrans    = 2'd0;
        hmastlock = 1'b0;
        hwait     = 1'b0;

        @(negedge hclk);
        checkOutput("reset hgrant", 32'(hgrant_o[0]), 32'd0);
        checkOutput("reset hsel", 32'(hsel_o[0]), 32'd0);
        checkOutput("reset hmaster", 32'(hmaster_o[0]), 32'd0);
        checkOutput("reset hlast", 32'(hlast_o[0]), 32'd0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;

        applyStimulus(4'b1111, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("fix idle before grant", 32'(hsel_o[0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 2'd2, 3'd0, 1'b0, 1'b0);
            @(negedge hclk);
            checkOutput("rr rotate hmaster", 32'(hmaster_o[2]), 32'(k % 4));
            checkOutput("rr single hlast", 32'(hlast_o[2]), 32'd1);
            if (k == 0) begin
                checkOutput("fix all-req hgrant", 32'(hgrant_o[0]), 32'h1);
                checkOutput("dyn tie hmaster", 32'(hmaster_o[1]), 32'd1);
            end
        end

        applyStimulus(4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(4'b0110, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("fix released hsel", 32'(hsel_o[0]), 32'd0);
        applyStimulus(4'b0110, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("fix 0110 hgrant", 32'(hgrant_o[0]), 32'h2);
        checkOutput("fix 0110 hmaster", 32'(hmaster_o[0]), 32'd1);
        checkOutput("dyn 0110 hmaster", 32'(hmaster_o[1]), 32'd1);

        applyStimulus(4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus((c == 9) ? 4'b0100 : 4'b0101, c_trans[c], 3'd5, 1'b0, c_wait[c]);
            @(negedge hclk);
            checkOutput("fix incr8 hlast", 32'(hlast_o[0]), (c == 9) ? 32'd1 : 32'd0);
            checkOutput("fix incr8 hgrant", 32'(hgrant_o[0]), c_wait[c] ? 32'h0 : 32'h1);
        end
        applyStimulus(4'b0100, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("fix handover hmaster", 32'(hmaster_o[0]), 32'd2);
        checkOutput("fix handover hgrant", 32'(hgrant_o[0]), 32'h4);

        applyStimulus(4'b0100, 2'd2, 3'd7, 1'b0, 1'b0);
        applyStimulus(4'b0100, 2'd3, 3'd7, 1'b0, 1'b0);
        applyStimulus(4'b0100, 2'd3, 3'd7, 1'b0, 1'b0);
        @(posedge hclk);
        #3;
        hreset_n = 1'b0;
        htrans   = 2'd0;
        #1;
        checkOutput("async rst hgrant", 32'(hgrant_o[0]), 32'd0);
        checkOutput("async rst hsel", 32'(hsel_o[0]), 32'd0);
        checkOutput("async rst hmaster", 32'(hmaster_o[0]), 32'd0);
        checkOutput("async rst hlast", 32'(hlast_o[0]), 32'd0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        @(negedge hclk);
        checkOutput("post rst idle hsel", 32'(hsel_o[0]), 32'd0);
        applyStimulus(4'b0100, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("post rst regrant hsel", 32'(hsel_o[0]), 32'd1);
        checkOutput("post rst regrant hmaster", 32'(hmaster_o[0]), 32'd2);

        applyStimulus(4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(4'b0011, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0011, (b == 0) ? 2'd2 : 2'd3, 3'd1, 1'b0, 1'b0);
            @(negedge hclk);
            checkOutput("rr incr cap hmaster", 32'(hmaster_o[2]), 32'd0);
            checkOutput("rr incr cap hlast", 32'(hlast_o[2]), (b == 3) ? 32'd1 : 32'd0);
        end
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0011, (b == 0) ? 2'd2 : 2'd3, 3'd1, (b == 3), 1'b0);
            @(negedge hclk);
            checkOutput("rr forced release hmaster", 32'(hmaster_o[2]), 32'd1);
            checkOutput("rr locked incr hlast", 32'(hlast_o[2]), (b == 3) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0011, 2'd0, 3'd0, (c < 2), 1'b0);
            @(negedge hclk);
            checkOutput("rr lock hold hmaster", 32'(hmaster_o[2]), 32'd1);
        end
        applyStimulus(4'b0011, 2'd0, 3'd0, 1'b0, 1'b0);
        @(negedge hclk);
        checkOutput("rr lock exit hmaster", 32'(hmaster_o[2]), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge hclk);
            #1;
            if ($urandom_range(0, 3) == 0) hreq = 4'($urandom);
            hprior    = 8'($urandom);
            hburst    = 3'($urandom);
            htrans    = 2'($urandom);
            hmastlock = ($urandom_range(0, 9) == 0);
            hwait     = ($urandom_range(0, 4) == 0);
            hreset_n  = ($urandom_range(0, 399) != 0);
        end

        @(negedge hclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
